// File: rtl/pcm_voice_sched.sv
`default_nettype none
// ============================================================================
// Module      : pcm_voice_sched
// Description : Multi-voice one-shot PCM scheduler. Time-shares one sync PCM
//               sample ROM read port between NVOICE voices, fetching one
//               byte per voice on every sample tick and mixing the results
//               into an 8-bit output sample.
// Revision    : 1.0 - initial release
// ============================================================================
module pcm_voice_sched #(
   parameter int NVOICE = 4,
   parameter int AW     = 15
) (
   input  logic              CLK24M,
   input  logic              RESET_N,
   input  logic              SMPL_TICK,
   input  logic [NVOICE-1:0] KICK,
   input  logic              CFG_WE,
   input  logic [2:0]        CFG_VOICE,
   input  logic              CFG_SEL,
   input  logic [AW-1:0]     CFG_DATA,
   output logic [AW-1:0]     ROM_AD,
   input  logic [7:0]        ROM_DT,
   output logic [NVOICE-1:0] BUSY,
   output logic              OVERRUN,
   output logic [7:0]        PCM_OUT
);

   localparam int VB    = (NVOICE > 1) ? $clog2(NVOICE) : 1;
   localparam int SHIFT = VB - 1;
   localparam int SW    = 10;   // 7-bit samples, up to 8 voices

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_MIX  = 2'd3;

   localparam logic [VB-1:0] LAST_V = VB'(NVOICE - 1);

   logic [1:0]        state, state_nxt;
   logic [VB-1:0]     vidx, vidx_nxt;
   logic              is_idle, do_addr, do_data, do_mix;
   logic [NVOICE-1:0] kick_hist;
   logic [AW-1:0]     ptr_w [NVOICE];
   logic [6:0]        smp_w [NVOICE];
   logic [NVOICE-1:0] busy_w;
   logic [VB-1:0]     cfg_idx;
   logic [SW-1:0]     sum, sum_sh;
   logic              unused;

   // Only the low index bits select a voice; the rest are don't-care.
   assign cfg_idx = CFG_VOICE[VB-1:0];
   assign BUSY    = busy_w;
   assign unused  = &{1'b0, CFG_VOICE, ROM_DT[0]};

   // Sequencer state register: phase plus the voice currently being served.
   always_ff @(posedge CLK24M or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= ST_IDLE;
         vidx  <= '0;
      end else begin
         state <= state_nxt;
         vidx  <= vidx_nxt;
      end
   end

   // Next-state: fixed ADDR/DATA pair per voice regardless of activity, then MIX.
   always_comb begin
      state_nxt = state;
      vidx_nxt  = vidx;
      case (state)
         ST_IDLE: begin
            if (SMPL_TICK) begin
               state_nxt = ST_ADDR;
               vidx_nxt  = '0;
            end
         end
         ST_ADDR: state_nxt = ST_DATA;
         ST_DATA: begin
            if (vidx == LAST_V) begin
               state_nxt = ST_MIX;
            end else begin
               state_nxt = ST_ADDR;
               vidx_nxt  = vidx + 1'b1;
            end
         end
         ST_MIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Phase decodes driving the datapath.
   always_comb begin
      is_idle = (state == ST_IDLE);
      do_addr = (state == ST_ADDR);
      do_data = (state == ST_DATA);
      do_mix  = (state == ST_MIX);
   end

   generate
      for (genvar v = 0; v < NVOICE; v++) begin : g_voice
         logic [AW-1:0] start_q, end_q, ptr_q, endc_q, ptr_inc;
         logic [6:0]    smp_q;
         logic          busy_q, pend_q, pend_eff, cfg_hit, sel;

         // A fresh rising edge is consumed in the same cycle if the sequencer is idle.
         assign pend_eff = pend_q | (KICK[v] & ~kick_hist[v]);
         assign cfg_hit  = CFG_WE && (cfg_idx == VB'(v));
         assign sel      = do_data && (vidx == VB'(v));
         assign ptr_inc  = ptr_q + 1'b1;

         assign ptr_w[v]  = ptr_q;
         assign smp_w[v]  = smp_q;
         assign busy_w[v] = busy_q;

         // Start/end configuration; only sampled into the voice when a kick is consumed.
         always_ff @(posedge CLK24M or negedge RESET_N) begin
            if (!RESET_N) begin
               start_q <= '0;
               end_q   <= '0;
            end else if (cfg_hit) begin
               if (CFG_SEL) end_q   <= CFG_DATA;
               else         start_q <= CFG_DATA;
            end
         end

         // Voice playback: kick consume in IDLE, one byte fetched per tick in DATA.
         always_ff @(posedge CLK24M or negedge RESET_N) begin
            if (!RESET_N) begin
               pend_q <= 1'b0;
               ptr_q  <= '0;
               endc_q <= '0;
               busy_q <= 1'b0;
               smp_q  <= '0;
            end else begin
               pend_q <= pend_eff & ~is_idle;
               if (is_idle && pend_eff) begin
                  ptr_q  <= start_q;
                  endc_q <= end_q;
                  busy_q <= (start_q < end_q);
               end else if (sel) begin
                  if (busy_q) begin
                     smp_q <= ROM_DT[7:1];
                     ptr_q <= ptr_inc;
                     if (ptr_inc >= endc_q) busy_q <= 1'b0;
                  end else begin
                     smp_q <= '0;
                  end
               end
            end
         end
      end
   endgenerate

   // Mixer: unsigned sum of all voice samples scaled back into 8 bits.
   always_comb begin
      sum = '0;
      for (int i = 0; i < NVOICE; i++) begin
         sum = sum + SW'(smp_w[i]);
      end
      sum_sh = sum >> SHIFT;
   end

   // ROM address, mixed output, kick history and sticky overrun flag.
   always_ff @(posedge CLK24M or negedge RESET_N) begin
      if (!RESET_N) begin
         kick_hist <= '1;
         ROM_AD    <= '0;
         PCM_OUT   <= '0;
         OVERRUN   <= 1'b0;
      end else begin
         kick_hist <= KICK;
         if (do_addr) ROM_AD <= ptr_w[vidx];
         if (do_mix)  PCM_OUT <= (sum_sh > SW'(255)) ? 8'hFF : sum_sh[7:0];
         if (SMPL_TICK && !is_idle) OVERRUN <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pcm_voice_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcm_voice_sched
// Description : Self-checking bench for pcm_voice_sched with a behavioural
//               voice model (base/length/position per voice).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcm_voice_sched;
   localparam int NV = 4;
   localparam int AW = 15;

   logic          clk, rst_n, smpl_tick, cfg_we, cfg_sel;
   logic [NV-1:0] kick;
   logic [2:0]    cfg_voice;
   logic [AW-1:0] cfg_data;
   logic [AW-1:0] rom_ad;
   logic [7:0]    rom_dt;
   logic [NV-1:0] busy;
   logic          overrun;
   logic [7:0]    pcm_out;

   logic [7:0] rom [0:(1<<AW)-1];

   int n_checks, n_err;

   // Behavioural model: each voice plays rom[base + k] for k = 0 .. len-1.
   int m_start[NV], m_end[NV], m_base[NV], m_len[NV], m_pos[NV], m_addr[NV];
   int m_pcm;
   int got_addr[NV];

   pcm_voice_sched #(.NVOICE(NV), .AW(AW)) dut (
      .CLK24M   (clk),
      .RESET_N  (rst_n),
      .SMPL_TICK(smpl_tick),
      .KICK     (kick),
      .CFG_WE   (cfg_we),
      .CFG_VOICE(cfg_voice),
      .CFG_SEL  (cfg_sel),
      .CFG_DATA (cfg_data),
      .ROM_AD   (rom_ad),
      .ROM_DT   (rom_dt),
      .BUSY     (busy),
      .OVERRUN  (overrun),
      .PCM_OUT  (pcm_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rom_dt = rom[rom_ad];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         m_start[v] = 0; m_end[v] = 0; m_base[v] = 0;
         m_len[v] = 0; m_pos[v] = 0; m_addr[v] = 0;
      end
      m_pcm = 0;
   endtask

   function automatic logic [NV-1:0] model_busy();
      logic [NV-1:0] b;
      for (int v = 0; v < NV; v++) b[v] = (m_pos[v] < m_len[v]);
      return b;
   endfunction

   task automatic model_tick();
      int s;
      s = 0;
      for (int v = 0; v < NV; v++) begin
         m_addr[v] = (m_base[v] + m_pos[v]) & ((1 << AW) - 1);
         if (m_pos[v] < m_len[v]) begin
            s += int'(rom[m_addr[v]]) / 2;
            m_pos[v]++;
         end
      end
      m_pcm = (s / 2 > 255) ? 255 : s / 2;
   endtask

   task automatic cfg_write(input int v, input bit sel, input int data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_voice = 3'(v); cfg_sel = sel; cfg_data = AW'(data);
      @(negedge clk);
      cfg_we = 1'b0;
      if (sel) m_end[v] = data; else m_start[v] = data;
   endtask

   task automatic do_kick(input logic [NV-1:0] mask);
      @(negedge clk);
      kick = mask;
      for (int v = 0; v < NV; v++) begin
         if (mask[v]) begin
            m_base[v] = m_start[v];
            m_len[v]  = (m_start[v] < m_end[v]) ? m_end[v] - m_start[v] : 0;
            m_pos[v]  = 0;
         end
      end
      @(negedge clk);
      kick = '0;
      chk("busy_after_kick", busy, model_busy());
   endtask

   task automatic do_tick();
      int prev;
      prev = m_pcm;
      model_tick();
      @(negedge clk); smpl_tick = 1'b1;
      @(negedge clk); smpl_tick = 1'b0;
      for (int v = 0; v < NV; v++) begin
         @(negedge clk);
         got_addr[v] = int'(rom_ad);
         chk("rom_ad", rom_ad, m_addr[v]);
         @(negedge clk);
      end
      chk("pcm_hold", pcm_out, prev);
      @(negedge clk);
      chk("pcm_out", pcm_out, m_pcm);
      chk("busy", busy, model_busy());
   endtask

   initial begin
      int prev, exp_seq[4], s, len, ticks;
      n_checks = 0; n_err = 0;
      rst_n = 1'b0; smpl_tick = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
      cfg_voice = '0; cfg_data = '0;
      for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
      model_reset();

      // Reset with all kicks held high; release must not trigger any voice.
      kick = '1;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_pcm", pcm_out, 0);
      chk("rst_rom_ad", rom_ad, 0);
      chk("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("held_kick_busy", busy, 0);
      repeat (3) do_tick();
      kick = '0;

      // Voice 0 plays three known bytes then stops.
      rom[15'h100] = 8'hFE; rom[15'h101] = 8'h80; rom[15'h102] = 8'h02;
      cfg_write(0, 1'b0, 'h100);
      cfg_write(0, 1'b1, 'h103);
      do_kick(4'b0001);
      exp_seq = '{'h3F, 'h20, 'h00, 'h00};
      for (int i = 0; i < 4; i++) begin
         do_tick();
         chk("v0_seq", pcm_out, exp_seq[i]);
         chk("v0_busy", busy[0], (i < 2) ? 1 : 0);
      end

      // All voices on full-scale bytes.
      for (int v = 0; v < NV; v++) begin
         for (int k = 0; k < 4; k++) rom['h300 + 16 * v + k] = 8'hFF;
         cfg_write(v, 1'b0, 'h300 + 16 * v);
         cfg_write(v, 1'b1, 'h304 + 16 * v);
      end
      do_kick(4'b1111);
      do_tick();
      chk("all_ff_pcm", pcm_out, 'hFE);
      for (int v = 0; v < NV; v++) chk("all_ff_addr", got_addr[v], 'h300 + 16 * v);

      // Empty voice never starts; retrigger restarts from START.
      cfg_write(2, 1'b0, 'h200);
      cfg_write(2, 1'b1, 'h200);
      do_kick(4'b0100);
      chk("empty_busy", busy[2], 0);
      cfg_write(1, 1'b0, 'h10);
      cfg_write(1, 1'b1, 'h20);
      do_kick(4'b0010);
      repeat (5) do_tick();
      do_kick(4'b0010);
      do_tick();
      chk("retrig_addr", got_addr[1], 'h10);

      // Second tick during a running sequence is ignored and flagged.
      chk("overrun_pre", overrun, 0);
      prev = m_pcm;
      model_tick();
      @(negedge clk); smpl_tick = 1'b1;
      @(negedge clk); smpl_tick = 1'b0;
      repeat (3) @(negedge clk);
      smpl_tick = 1'b1;
      @(negedge clk); smpl_tick = 1'b0;
      chk("overrun_set", overrun, 1);
      repeat (4) @(negedge clk);
      chk("ovr_pcm_hold", pcm_out, prev);
      @(negedge clk);
      chk("ovr_pcm", pcm_out, m_pcm);
      repeat (3) @(negedge clk);
      chk("ovr_no_extra_mix", pcm_out, m_pcm);

      // Asynchronous reset in the middle of DATA(2).
      do_kick(4'b1011);
      do_tick();
      @(negedge clk); smpl_tick = 1'b1;
      @(negedge clk); smpl_tick = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("amid_busy", busy, 0);
      chk("amid_pcm", pcm_out, 0);
      chk("amid_rom_ad", rom_ad, 0);
      chk("amid_overrun", overrun, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cfg_write(0, 1'b0, 'h100);
      cfg_write(0, 1'b1, 'h103);
      do_kick(4'b0001);
      do_tick();
      chk("post_rst_pcm", pcm_out, 'h3F);

      // Randomised rounds: random configs, kick masks, retriggers and re-configs.
      for (int r = 0; r < 10; r++) begin
         for (int v = 0; v < NV; v++) begin
            s   = int'($urandom_range(16'h0400, 16'h7F00));
            len = int'($urandom_range(0, 6));
            cfg_write(v, 1'b0, s);
            cfg_write(v, 1'b1, (len == 0) ? s - int'($urandom_range(0, 3)) : s + len);
         end
         do_kick(NV'($urandom_range(1, 15)));
         ticks = int'($urandom_range(2, 7));
         for (int t = 0; t < ticks; t++) begin
            if ($urandom_range(0, 3) == 0)
               cfg_write(int'($urandom_range(0, NV - 1)), 1'($urandom), int'($urandom_range(16'h0400, 16'h7F00)));
            if ($urandom_range(0, 3) == 0)
               do_kick(NV'($urandom_range(1, 15)));
            do_tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
